// File: rtl/cfg_info_frm_rx_if.sv
// Byte-stream and replay-window signals of the configuration-info frame receiver.
// master drives the slink byte stream; slave is the receiver that replays accepted payloads.
interface cfg_info_frm_rx_if;
  logic        slink_rx_dval;
  logic        slink_rx_sof;
  logic [7:0]  slink_rx_data;
  logic        cfg_param_dval;
  logic [7:0]  slink_cfg_data;
  logic        frm_ok;
  logic        frm_err;
  logic [1:0]  err_code;
  logic [15:0] frm_ok_cnt;

  modport master (
    output slink_rx_dval,
    output slink_rx_sof,
    output slink_rx_data,
    input  cfg_param_dval,
    input  slink_cfg_data,
    input  frm_ok,
    input  frm_err,
    input  err_code,
    input  frm_ok_cnt
  );

  modport slave (
    input  slink_rx_dval,
    input  slink_rx_sof,
    input  slink_rx_data,
    output cfg_param_dval,
    output slink_cfg_data,
    output frm_ok,
    output frm_err,
    output err_code,
    output frm_ok_cnt
  );
endinterface

// File: rtl/cfg_info_frm_rx.sv
// Configuration-info frame receiver: validates HDR/TYPE/LEN, buffers the payload and replays it
// as one gap-free window once accepted. Define CFG_FRM_CRC_EN to add the trailing CRC-16 check.
module cfg_info_frm_rx #(
  parameter int unsigned PAYLOAD_LEN = 24,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  FRM_TYPE    = 8'h03,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  cfg_info_frm_rx_if.slave bus
);

  localparam int unsigned      IdxW    = $clog2(PAYLOAD_LEN);
  localparam int unsigned      TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(PAYLOAD_LEN - 1);
  localparam logic [7:0]       LenByte = 8'(PAYLOAD_LEN);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       ErrFmt  = 2'd1;
  localparam logic [1:0]       ErrTmo  = 2'd3;
`ifdef CFG_FRM_CRC_EN
  localparam logic [1:0]       ErrCrc  = 2'd2;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StLen,
    StPayld,
    StCrcH,
    StCrcL,
    StCheck,
    StReplay
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] rd_q, rd_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            dval_q, dval_d;
  logic [7:0]      data_q, data_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            wr_en;
  logic            err_hit;
  logic [1:0]      err_kind;
  logic            in_frame;
  logic            rx_byte;

  logic [7:0]      pld_mem [PAYLOAD_LEN];

`ifdef CFG_FRM_CRC_EN
  logic [15:0]     crc_q, crc_d;
  logic [7:0]      crc_hi_q, crc_hi_d;

  // CRC-16/CCITT, MSB first, one byte per call.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] r;
    r = crc ^ {din, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign rx_byte  = bus.slink_rx_dval && !bus.slink_rx_sof;
  assign in_frame = (state_q inside {StType, StLen, StPayld, StCrcH, StCrcL});

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_d     = rd_q;
    tmo_d    = tmo_q;
    dval_d   = 1'b0;
    data_d   = 8'h00;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    err_hit  = 1'b0;
    err_kind = 2'd0;
`ifdef CFG_FRM_CRC_EN
    crc_d    = crc_q;
    crc_hi_d = crc_hi_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.slink_rx_dval && bus.slink_rx_sof) begin
          if (bus.slink_rx_data == HDR_BYTE) begin
            state_d = StType;
            tmo_d   = '0;
`ifdef CFG_FRM_CRC_EN
            crc_d   = 16'hFFFF;
`endif
          end else begin
            err_hit  = 1'b1;
            err_kind = ErrFmt;
          end
        end
      end
      StType: begin
        if (rx_byte) begin
          if (bus.slink_rx_data != FRM_TYPE) begin
            err_hit  = 1'b1;
            err_kind = ErrFmt;
            state_d  = StIdle;
          end else begin
            state_d = StLen;
`ifdef CFG_FRM_CRC_EN
            crc_d   = crc16_upd(crc_q, bus.slink_rx_data);
`endif
          end
        end
      end
      StLen: begin
        if (rx_byte) begin
          if (bus.slink_rx_data != LenByte) begin
            err_hit  = 1'b1;
            err_kind = ErrFmt;
            state_d  = StIdle;
          end else begin
            state_d = StPayld;
            idx_d   = '0;
`ifdef CFG_FRM_CRC_EN
            crc_d   = crc16_upd(crc_q, bus.slink_rx_data);
`endif
          end
        end
      end
      StPayld: begin
        if (rx_byte) begin
          wr_en = 1'b1;
`ifdef CFG_FRM_CRC_EN
          crc_d = crc16_upd(crc_q, bus.slink_rx_data);
`endif
          if (idx_q == LastIdx) begin
`ifdef CFG_FRM_CRC_EN
            state_d = StCrcH;
`else
            state_d = StCheck;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef CFG_FRM_CRC_EN
      StCrcH: begin
        if (rx_byte) begin
          crc_hi_d = bus.slink_rx_data;
          state_d  = StCrcL;
        end
      end
      StCrcL: begin
        if (rx_byte) begin
          if ({crc_hi_q, bus.slink_rx_data} == crc_q) begin
            state_d = StCheck;
          end else begin
            err_hit  = 1'b1;
            err_kind = ErrCrc;
            state_d  = StIdle;
          end
        end
      end
`endif
      StCheck: begin
        state_d = StReplay;
        dval_d  = 1'b1;
        data_d  = pld_mem[0];
        rd_d    = '0;
        ok_d    = 1'b1;
        cnt_d   = cnt_q + 16'd1;
      end
      StReplay: begin
        // rd_q is the index currently on the output; the window ends after LastIdx.
        if (rd_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          rd_d    = rd_q + 1'b1;
          dval_d  = 1'b1;
          data_d  = pld_mem[rd_q + 1'b1];
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame-wide rules: a sof aborts and restarts, idle cycles feed the timeout.
    if (in_frame) begin
      if (bus.slink_rx_dval) begin
        tmo_d = '0;
        if (bus.slink_rx_sof) begin
          err_hit  = 1'b1;
          err_kind = ErrFmt;
          wr_en    = 1'b0;
          if (bus.slink_rx_data == HDR_BYTE) begin
            state_d = StType;
`ifdef CFG_FRM_CRC_EN
            crc_d   = 16'hFFFF;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end else if (tmo_q == TmoLast) begin
        err_hit  = 1'b1;
        err_kind = ErrTmo;
        state_d  = StIdle;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (err_hit) begin
      err_d  = 1'b1;
      code_d = err_kind;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rd_q     <= '0;
      tmo_q    <= '0;
      dval_q   <= 1'b0;
      data_q   <= 8'h00;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      cnt_q    <= 16'd0;
`ifdef CFG_FRM_CRC_EN
      crc_q    <= 16'hFFFF;
      crc_hi_q <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_q     <= rd_d;
      tmo_q    <= tmo_d;
      dval_q   <= dval_d;
      data_q   <= data_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
`ifdef CFG_FRM_CRC_EN
      crc_q    <= crc_d;
      crc_hi_q <= crc_hi_d;
`endif
    end
  end

  // Payload store needs no reset; it is only read after a full frame has been written.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      pld_mem[idx_q] <= bus.slink_rx_data;
    end
  end

  assign bus.cfg_param_dval = dval_q;
  assign bus.slink_cfg_data = data_q;
  assign bus.frm_ok         = ok_q;
  assign bus.frm_err        = err_q;
  assign bus.err_code       = code_q;
  assign bus.frm_ok_cnt     = cnt_q;

endmodule

// File: tb/tb_cfg_info_frm_rx.sv
// Directed bench for cfg_info_frm_rx: good, gapped, malformed, timed-out and aborted frames.
// Follows CFG_FRM_CRC_EN so CRC bytes and the CRC error case track the RTL build.
module tb_cfg_info_frm_rx;
  localparam int unsigned PldLen = 24;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  cfg_info_frm_rx_if sl ();

  cfg_info_frm_rx #(
    .PAYLOAD_LEN (PldLen),
    .HDR_BYTE    (8'hA5),
    .FRM_TYPE    (8'h03),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (sl.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int exp_cnt = 0;
  logic [7:0] pld [PldLen];

  // Window monitor
  bit         prev_dval = 1'b0;
  int         runs, cur_run, run_len, ok_n, ok_bad, err_n, first_cyc;
  logic [7:0] win [$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (sl.cfg_param_dval === 1'b1) begin
      if (!prev_dval) begin
        first_cyc = cyc;
        runs++;
      end
      win.push_back(sl.slink_cfg_data);
      cur_run++;
    end else if (prev_dval) begin
      run_len = cur_run;
      cur_run = 0;
    end
    if (sl.frm_ok === 1'b1) begin
      ok_n++;
      if (!(sl.cfg_param_dval === 1'b1 && !prev_dval)) ok_bad++;
    end
    if (sl.frm_err === 1'b1) err_n++;
    prev_dval = (sl.cfg_param_dval === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    runs = 0; cur_run = 0; run_len = 0; ok_n = 0; ok_bad = 0; err_n = 0; first_cyc = 0;
    win.delete();
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic send_byte(input bit sof, input logic [7:0] d, input int gap);
    repeat (gap) begin
      @(posedge clk_sys); #1;
      sl.slink_rx_dval = 1'b0;
      sl.slink_rx_sof  = 1'b0;
    end
    @(posedge clk_sys); #1;
    sl.slink_rx_dval = 1'b1;
    sl.slink_rx_sof  = sof;
    sl.slink_rx_data = d;
    last_cyc = cyc;
  endtask

  task automatic go_idle();
    @(posedge clk_sys); #1;
    sl.slink_rx_dval = 1'b0;
    sl.slink_rx_sof  = 1'b0;
  endtask

  task automatic settle();
    repeat (40) @(posedge clk_sys);
    #1;
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
  endfunction

  task automatic send_frame(input logic [7:0] typ, input logic [7:0] len, input int max_gap,
                            input bit flip5);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    c = crc_step(c, typ);
    c = crc_step(c, len);
    send_byte(1'b1, 8'hA5, 0);
    send_byte(1'b0, typ, pick_gap(max_gap));
    send_byte(1'b0, len, pick_gap(max_gap));
    for (int i = 0; i < PldLen; i++) begin
      b = pld[i];
      c = crc_step(c, b);
      if (flip5 && i == 5) b = b ^ 8'h01;
      send_byte(1'b0, b, pick_gap(max_gap));
    end
`ifdef CFG_FRM_CRC_EN
    send_byte(1'b0, c[15:8], pick_gap(max_gap));
    send_byte(1'b0, c[7:0], pick_gap(max_gap));
`endif
    go_idle();
  endtask

  task automatic chk_good(input string tag, input int exp_err, input logic [1:0] exp_code,
                          input bit chk_lat);
    logic [31:0] got;
    chk({tag, "/runs"}, runs, 1);
    chk({tag, "/run_len"}, run_len, PldLen);
    for (int i = 0; i < PldLen; i++) begin
      got = (i < win.size()) ? 32'(win[i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s/win[%0d]", tag, i), got, 32'(pld[i]));
    end
    if (chk_lat) chk({tag, "/latency"}, first_cyc - last_cyc, 2);
    chk({tag, "/ok_pulses"}, ok_n, 1);
    chk({tag, "/ok_align"}, ok_bad, 0);
    chk({tag, "/err_pulses"}, err_n, exp_err);
    chk({tag, "/err_code"}, sl.err_code, exp_code);
    chk({tag, "/ok_cnt"}, sl.frm_ok_cnt, exp_cnt);
    chk({tag, "/dval_after"}, sl.cfg_param_dval, 0);
  endtask

  task automatic chk_reject(input string tag, input logic [1:0] exp_code);
    chk({tag, "/err_pulses"}, err_n, 1);
    chk({tag, "/err_code"}, sl.err_code, exp_code);
    chk({tag, "/runs"}, runs, 0);
    chk({tag, "/ok_cnt"}, sl.frm_ok_cnt, exp_cnt);
  endtask

  task automatic wait_window(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (sl.cfg_param_dval === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk_sys); #1;
      end
    end
    chk({tag, "/window_seen"}, seen, 1);
  endtask

  initial begin
    logic [7:0] w [4];
    sl.slink_rx_dval = 1'b0;
    sl.slink_rx_sof  = 1'b0;
    sl.slink_rx_data = 8'h00;
    for (int i = 0; i < PldLen; i++) pld[i] = 8'(i);
    clr_mon();

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst/dval", sl.cfg_param_dval, 0);
    chk("rst/data", sl.slink_cfg_data, 0);
    chk("rst/ok", sl.frm_ok, 0);
    chk("rst/err", sl.frm_err, 0);
    chk("rst/code", sl.err_code, 0);
    chk("rst/cnt", sl.frm_ok_cnt, 0);
    rst_sys_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // Contiguous good frame
    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b0);
    settle();
    exp_cnt = 1;
    chk_good("good", 0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) w[i] = (i < win.size()) ? win[i] : 8'hEE;
    chk("good/param0", {w[2], w[3], w[0], w[1]}, 32'h0203_0001);

    // Same frame with random inter-byte gaps
    clr_mon();
    send_frame(8'h03, 8'h18, 5, 1'b0);
    settle();
    exp_cnt = 2;
    chk_good("gapped", 0, 2'd0, 1'b1);

    clr_mon();
    send_frame(8'h04, 8'h18, 0, 1'b0);
    settle();
    chk_reject("bad_type", 2'd1);

    clr_mon();
    send_frame(8'h03, 8'h17, 0, 1'b0);
    settle();
    chk_reject("bad_len", 2'd1);

`ifdef CFG_FRM_CRC_EN
    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b1);
    settle();
    chk_reject("bad_crc", 2'd2);
    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b0);
    settle();
    exp_cnt++;
    chk_good("after_crc", 0, 2'd2, 1'b1);
`endif

    // Stall after 10 payload bytes
    clr_mon();
    send_byte(1'b1, 8'hA5, 0);
    send_byte(1'b0, 8'h03, 0);
    send_byte(1'b0, 8'h18, 0);
    for (int i = 0; i < 10; i++) send_byte(1'b0, pld[i], 0);
    go_idle();
    repeat (990) @(posedge clk_sys);
    #1;
    chk("tmo/early", err_n, 0);
    repeat (30) @(posedge clk_sys);
    #1;
    chk_reject("tmo", 2'd3);
    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b0);
    settle();
    exp_cnt++;
    chk_good("after_tmo", 0, 2'd3, 1'b1);

    // sof+A5 mid-payload restarts the frame from that byte
    clr_mon();
    send_byte(1'b1, 8'hA5, 0);
    send_byte(1'b0, 8'h03, 0);
    send_byte(1'b0, 8'h18, 0);
    for (int i = 0; i < 5; i++) send_byte(1'b0, 8'hC0 + 8'(i), 0);
    send_frame(8'h03, 8'h18, 0, 1'b0);
    settle();
    exp_cnt++;
    chk_good("restart", 1, 2'd1, 1'b1);

    // sof traffic during the replay window is ignored
    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b0);
    wait_window("replay_sof");
    send_byte(1'b1, 8'hA5, 0);
    send_byte(1'b0, 8'h03, 0);
    send_byte(1'b0, 8'h18, 0);
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h55, 0);
    go_idle();
    settle();
    exp_cnt++;
    chk_good("replay_sof", 0, 2'd1, 1'b0);

    // Asynchronous reset in the middle of a window
    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b0);
    wait_window("mid_rst");
    repeat (3) @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b0;
    #2;
    chk("mid_rst/dval", sl.cfg_param_dval, 0);
    chk("mid_rst/cnt", sl.frm_ok_cnt, 0);
    chk("mid_rst/code", sl.err_code, 0);
    @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b1;
    @(posedge clk_sys);
    #1;

    clr_mon();
    send_frame(8'h03, 8'h18, 0, 1'b0);
    settle();
    exp_cnt = 1;
    chk_good("post_rst", 0, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
